buffer_write_arbiter: RTL
=========================

Name: buffer_write_arbiter

Overview:
- Weighted round-robin arbiter that shares the single write port of a circular_buffer instance among NUM_REQ producers, for example multiple fetch/decode lanes or writeback sources feeding one queue.
- Each producer uses a valid/ready handshake.
- The arbiter drives the buffer's write_en/write_data and backs off on the buffer's full flag.
- Per-requester burst weights are runtime-configurable, and per-requester saturating grant counters are kept for performance monitoring.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- T, logic [31:0], payload type; must match the buffer's T.
- WEIGHT_W, 3, width of each per-requester burst weight.
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- flush  in  1  pipeline flush: suppress grants and restart arbitration.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ x T  per-requester payload.
- req_ready  out  NUM_REQ  one-hot (or zero) accept; a beat transfers when req_valid[i] && req_ready[i].
- cfg_weight  in  NUM_REQ x WEIGHT_W  maximum consecutive beats per tenure; 0 is treated as 1.
- buf_full  in  1  full flag from the circular buffer.
- buf_write_en  out  1  write strobe to the buffer.
- buf_write_data  out  T  payload to the buffer.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner (valid when buf_write_en=1).
- grant_cnt  out  NUM_REQ x CNT_W  accepted beats per requester, saturating.

Behaviour:

Reset (reset==0, synchronous):
- rr_ptr=0, owner_valid=0, burst_cnt=0, every grant_cnt=0.
- Combinational outputs are 0 during reset: req_ready=0, buf_write_en=0.

Path and latency:
- Grant path is combinational, zero latency: a beat offered in cycle t is written into the buffer at the clk edge ending cycle t.

Blocking conditions:
- No grant in a cycle if buf_full==1, flush==1, or reset==0.
- In that cycle req_ready=0 and buf_write_en=0.

State machine (2 states):
- IDLE (owner_valid=0):
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - On a beat: owner=i, burst_cnt=1.
  - Go to BURST only if eff_weight(i)>1; otherwise rr_ptr=(i+1) mod NUM_REQ and stay in IDLE.
- BURST (owner_valid=1):
  - If req_valid[owner]=1 and not blocked, the owner is granted and burst_cnt increments.
  - When burst_cnt reaches eff_weight(owner), or req_valid[owner] drops, return to IDLE with rr_ptr=(owner+1) mod NUM_REQ.
  - If req_valid[owner]=0 in BURST, the same cycle falls through to an IDLE-style round-robin pick, so no bubble is inserted.
- buf_full==1 in BURST: hold state, do not increment burst_cnt, tenure is preserved.

Outputs:
- buf_write_en = |(req_valid & req_ready).
- buf_write_data = req_data[grant_id].
- grant_id holds its last value when idle.

Handshake rules:
- req_ready depends on req_valid of other requesters only through arbitration; it never depends on the same requester's own req_data.
- Producers must not drop req_valid without a transfer. The arbiter tolerates it: no beat is issued and the tenure ends as described above.

Flush:
- Highest priority after reset.
- Sets owner_valid=0, burst_cnt=0, rr_ptr=0. grant_cnt is not cleared.

Weights:
- cfg_weight is sampled when a tenure starts.
- Changes mid-burst take effect at the next tenure.

grant_cnt[i]:
- Increments on each beat of requester i.
- Saturates at 2^CNT_W-1; no wrap-around.

Wrap-around:
- rr_ptr wraps from NUM_REQ-1 to 0.
- If NUM_REQ is not a power of 2, explicit modulo is required.

Decomposition:
- Shared package (buf_arb_pkg): NUM_REQ_DEFAULT, REQ_ID_W=$clog2(NUM_REQ), arbiter state enum {ARB_IDLE, ARB_BURST}.
- One natural sub-module: rr_priority_picker. Combinational; inputs req mask and rr_ptr; outputs one-hot grant and encoded id. Reusable by other schedulers in the core.

Test Plan:
- Reset: reset=0 for 2 cycles with all req_valid=1 → req_ready=0, buf_write_en=0, grant_cnt all 0. First cycle after release grants requester 0.
- Fair RR: weights all 1, req_valid=4'b1111 for 8 cycles, buf_full=0 → grant_id sequence 0,1,2,3,0,1,2,3; each grant_cnt=2.
- Weighted burst: cfg_weight={1,1,1,3} (req0 weight=3), req0 and req2 valid for 8 cycles → grant sequence 0,0,0,2,0,0,0,2.
- Backpressure: buf_full=1 for 3 cycles in the middle of a req0 burst after 1 beat → no writes, req_ready=0. After full clears, 2 more req0 beats, then rotation to the next requester.
- Flush: flush=1 during req2's tenure with rr_ptr=3 → that cycle has no write. Next cycle with all valid grants requester 0; grant_cnt is unchanged by the flush.
- Saturation and wrap: CNT_W=4, req1 alone valid for 20 beats → grant_cnt[1]=15 and holds. rr_ptr wraps correctly with NUM_REQ=3.

Source files
------------

// File: rtl/buf_arb_pkg.sv
// Shared types and defaults for buffer write-port arbitration.
package buf_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 4;
    localparam int unsigned REQ_ID_W        = $clog2(NUM_REQ_DEFAULT);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_priority_picker
    import buf_arb_pkg::*;
#(
    parameter int unsigned N    = NUM_REQ_DEFAULT,
    parameter int unsigned ID_W = REQ_ID_W
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            found
);

    int unsigned idx;

    always_comb begin
        idx   = 0;
        id    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = ID_W'(idx);
            end
        end
        grant = found ? (N'(1) << id) : '0;
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Weighted round-robin arbiter sharing one circular-buffer write port among NUM_REQ producers.
module buffer_write_arbiter
    import buf_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ  = NUM_REQ_DEFAULT,
    parameter type          T        = logic [31:0],
    parameter int unsigned  WEIGHT_W = 3,
    parameter int unsigned  CNT_W    = 16,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  T                                 req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][WEIGHT_W-1:0] cfg_weight,
    input  logic                             buf_full,
    output logic                             buf_write_en,
    output T                                 buf_write_data,
    output logic [ID_W-1:0]                  grant_id,
    output logic [NUM_REQ-1:0][CNT_W-1:0]    grant_cnt
);

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (32'(id) == NUM_REQ - 1) ? '0 : ID_W'(32'(id) + 1);
    endfunction

    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    arb_state_e                    state_q, state_d;
    logic [ID_W-1:0]               owner_q, owner_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]               last_id_q, last_id_d;
    logic [WEIGHT_W-1:0]           burst_cnt_q, burst_cnt_d;
    logic [WEIGHT_W-1:0]           weight_q, weight_d;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic               blocked, keep_owner, pick_found, beat;
    logic [ID_W-1:0]    pick_ptr, pick_id, win_id;
    logic [NUM_REQ-1:0] pick_oh;

    // An owner that drops valid mid-burst hands priority to the next index in the same cycle.
    assign blocked    = !reset || flush || buf_full;
    assign keep_owner = (state_q == ARB_BURST) && req_valid[owner_q];
    assign pick_ptr   = (state_q == ARB_BURST) ? next_id(owner_q) : rr_ptr_q;

    rr_priority_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (pick_ptr),
        .grant (pick_oh),
        .id    (pick_id),
        .found (pick_found)
    );

    assign win_id         = keep_owner ? owner_q : pick_id;
    assign beat           = (keep_owner || pick_found) && !blocked;
    assign req_ready      = beat ? (keep_owner ? (NUM_REQ'(1) << owner_q) : pick_oh) : '0;
    assign buf_write_en   = |(req_valid & req_ready);
    assign buf_write_data = req_data[win_id];
    assign grant_id       = beat ? win_id : last_id_q;
    assign grant_cnt      = cnt_q;

    // Tenure tracking, round-robin pointer and saturating beat counters.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        weight_d    = weight_q;
        last_id_d   = grant_id;
        cnt_d       = cnt_q;

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (beat && win_id == ID_W'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        if (flush) begin
            state_d     = ARB_IDLE;
            rr_ptr_d    = '0;
            burst_cnt_d = '0;
        end else if (!buf_full) begin
            if (keep_owner) begin
                burst_cnt_d = burst_cnt_q + WEIGHT_W'(1);
                if (burst_cnt_d >= weight_q) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_id(owner_q);
                end
            end else begin
                if (state_q == ARB_BURST) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_id(owner_q);
                end
                if (pick_found) begin
                    owner_d     = pick_id;
                    burst_cnt_d = WEIGHT_W'(1);
                    weight_d    = eff_weight(cfg_weight[pick_id]);
                    if (weight_d > WEIGHT_W'(1)) begin
                        state_d = ARB_BURST;
                    end else begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_id(pick_id);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            last_id_q   <= '0;
            burst_cnt_q <= '0;
            weight_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
            weight_q    <= weight_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
